input_vector_loader: RTL
========================

INPUT_VECTOR_LOADER -- requirements
Module: input_vector_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bits per fixed-point sample.
REQ-002 Parameter FRACT_WIDTH, default 8, fraction bits; carried only, no arithmetic applied.
REQ-003 Parameter N_IN, default 500, samples per vector; legal range 2..1024.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous discard of partial or held vector.
REQ-007 in_data  input  DATA_WIDTH  streamed sample.
REQ-008 in_valid  input  1  in_data valid this cycle.
REQ-009 in_last  input  1  marks final sample of a short vector; qualified by in_valid.
REQ-010 in_ready  output  1  loader accepts a sample this cycle.
REQ-011 vec_data  output  N_IN*DATA_WIDTH  flattened vector; slot k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 vec_valid  output  1  vec_data complete and stable.
REQ-013 vec_ready  input  1  downstream adder stage consumes vector.
REQ-014 vec_count  output  clog2(N_IN+1)  number of loaded (non-padded) slots.

Function
REQ-015 States: FILL (accepting samples), PAD (zero-filling after in_last), FULL (vector held).
REQ-016 Sample accepted when in_valid && in_ready; stored to slot wr_idx, wr_idx increments by 1.
REQ-017 in_ready = 1 in FILL only; 0 in PAD and FULL (combinational from state register).
REQ-018 Accepting slot N_IN-1 moves FILL->FULL next cycle; vec_count = N_IN.
REQ-019 Accepting in_last at slot k < N_IN-1 moves FILL->PAD; vec_count = k+1.
REQ-020 PAD writes zero to one slot per cycle from k+1 to N_IN-1, then moves to FULL.
REQ-021 in_last on slot N_IN-1 behaves as REQ-018 (no PAD state entered).
REQ-022 vec_valid = 1 exactly in FULL; vec_data and vec_count constant while FULL.
REQ-023 FULL with vec_ready = 1: next cycle state FILL, wr_idx = 0, vec_valid = 0; no sample accepted in that handshake cycle.
REQ-024 Latency: vec_valid rises the cycle after the final store (full vector) or after the final pad write.
REQ-025 Slots not rewritten keep prior values until overwritten; downstream reads only when vec_valid = 1.
REQ-026 clear = 1: next state FILL, wr_idx = 0, vec_count = 0; any sample offered that cycle is dropped; clear has priority over handshakes.
REQ-027 in_last with in_valid = 0 is ignored.
REQ-028 vec_ready while not FULL is ignored.

Reset
REQ-029 reset = 1 forces state FILL, wr_idx = 0, vec_count = 0, vec_valid = 0, all vec_data slots zero.
REQ-030 reset has priority over clear and all handshakes; reset mid-fill or mid-PAD discards the partial vector.
REQ-031 in_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-032 Shared package lstm_pkg holds DATA_WIDTH, FRACT_WIDTH, N_IN defaults and the loader state enum.
REQ-033 No sub-module; write-index counter and slot register array inline; output feeds VariableInputAdd inputs directly.

Verification (bench with N_IN = 4, DATA_WIDTH = 16)
REQ-034 Stream 0x0100,0x0200,0x0300,0x0400 back-to-back -> vec_valid next cycle, vec_data = {0x0400,0x0300,0x0200,0x0100}, vec_count = 4, in_ready = 0.
REQ-035 Stream 0x0A00, then 0x0B00 with in_last -> two PAD cycles, vec_data = {0,0,0x0B00,0x0A00}, vec_count = 2.
REQ-036 Hold vec_ready = 0 for 10 cycles with in_valid = 1 -> vec_data unchanged, no samples accepted; pulse vec_ready -> in_ready = 1 next cycle, vec_valid = 0.
REQ-037 After 2 samples assert clear with in_valid = 1, data 0x7777 -> 0x7777 dropped; next 4 samples form a fresh vector, vec_count = 4.
REQ-038 reset asserted during PAD -> next cycle vec_valid = 0, vec_data all zero, in_ready = 1.
REQ-039 Random in_valid gaps (50 %) over 100 vectors -> every vector matches scoreboard order; no sample lost or duplicated.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared LSTM datapath defaults and the input loader state encoding.
//   LSTM_DATA_WIDTH  : bits per fixed-point sample
//   LSTM_FRACT_WIDTH : fraction bits (carried only)
//   LSTM_N_IN        : samples per input vector
//   loader_state_e   : FILL / PAD / FULL encoding of input_vector_loader
package lstm_pkg;

  localparam int unsigned LSTM_DATA_WIDTH  = 16;
  localparam int unsigned LSTM_FRACT_WIDTH = 8;
  localparam int unsigned LSTM_N_IN        = 500;

  typedef enum logic [1:0] {
    LOADER_FILL = 2'd0,
    LOADER_PAD  = 2'd1,
    LOADER_FULL = 2'd2
  } loader_state_e;

endpackage

// File: rtl/input_vector_loader.sv
// Collects a stream of fixed-point samples into one flattened N_IN-slot
// vector for the VariableInputAdd stage. A short vector (in_last before the
// final slot) is zero-padded up to N_IN slots before being presented.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clear                 : synchronous discard of partial or held vector
//   in_data/in_valid/
//   in_last/in_ready      : sample stream (in_last qualified by in_valid)
//   vec_data              : slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   vec_valid/vec_ready   : vector handshake, vec_valid high only when held
//   vec_count             : number of loaded (non-padded) slots
module input_vector_loader
  import lstm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int unsigned FRACT_WIDTH = LSTM_FRACT_WIDTH,
  parameter int unsigned N_IN        = LSTM_N_IN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [N_IN*DATA_WIDTH-1:0]   vec_data,
  output logic                         vec_valid,
  input  logic                         vec_ready,
  output logic [$clog2(N_IN+1)-1:0]    vec_count
);

  localparam int unsigned CNT_W = $clog2(N_IN + 1);

  localparam logic [1:0] S_FILL = LOADER_FILL;
  localparam logic [1:0] S_PAD  = LOADER_PAD;
  localparam logic [1:0] S_FULL = LOADER_FULL;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

  // Reject parameter sets the loader cannot represent.
  if (N_IN < 2 || N_IN > 1024 || FRACT_WIDTH > DATA_WIDTH) begin : g_param_check
    $error("input_vector_loader: illegal parameter set");
  end

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      wr_idx;
  logic [CNT_W-1:0]      idx_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // Next state, write index, loaded count and slot write request.
  always_comb begin
    state_nxt = state;
    idx_nxt   = wr_idx;
    cnt_nxt   = vec_count;
    wr_en     = 1'b0;
    wr_val    = '0;
    case (state)
      S_FILL: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_val  = in_data;
          cnt_nxt = wr_idx + CNT_W'(1);
          if (wr_idx == LAST_IDX) begin
            state_nxt = S_FULL;
          end else begin
            idx_nxt = wr_idx + CNT_W'(1);
            if (in_last) state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        // Zero one slot per cycle; wr_val already defaults to zero.
        wr_en = 1'b1;
        if (wr_idx == LAST_IDX) state_nxt = S_FULL;
        else                    idx_nxt   = wr_idx + CNT_W'(1);
      end
      S_FULL: begin
        if (vec_ready) begin
          state_nxt = S_FILL;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_FILL;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
    // Clear wins over any handshake and drops the sample offered with it.
    if (clear) begin
      state_nxt = S_FILL;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      wr_en     = 1'b0;
    end
  end

  // State, counters, registered handshake flags and the slot array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FILL;
      wr_idx    <= '0;
      vec_count <= '0;
      vec_valid <= 1'b0;
      in_ready  <= 1'b1;
      vec_data  <= '0;
    end else begin
      state     <= state_nxt;
      wr_idx    <= idx_nxt;
      vec_count <= cnt_nxt;
      vec_valid <= (state_nxt == S_FULL);
      in_ready  <= (state_nxt == S_FILL);
      if (wr_en) vec_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] <= wr_val;
    end
  end

endmodule
